// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for pipelined_memory. Holds the
//               controller state encoding and the byte-range check used by
//               both the read ports and the write port.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Controller state: MEM_CLEAR while the post-reset zeroing sweep runs,
    // MEM_READY once the array accepts traffic.
    typedef enum logic [0:0] {
        MEM_CLEAR = 1'b0,
        MEM_READY = 1'b1
    } mem_state_e;

    // Width used for range arithmetic. One bit wider than the widest
    // supported address, so addr + nbytes never wraps back into range.
    localparam int RANGE_WIDTH = 65;

    // True when bytes [addr, addr+nbytes) all lie inside [0, size).
    function automatic logic in_range(
        input logic [RANGE_WIDTH-1:0] addr,
        input logic [RANGE_WIDTH-1:0] nbytes,
        input logic [RANGE_WIDTH-1:0] size
    );
        return (addr + nbytes) <= size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_read_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_pipe
// Description : Fixed-depth delay line carrying one read response
//               (valid/data/fault). A synchronous reset flushes every stage,
//               discarding responses still in flight.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               in_valid/in_data/in_fault    - response entering stage 0
//               out_valid/out_data/out_fault - response leaving last stage
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_fault,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_fault
);

    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [LATENCY-1:0]    fault_q, fault_d;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_d [LATENCY];

    always_comb begin
        valid_d   = '0;
        fault_d   = '0;
        valid_d[0] = in_valid;
        fault_d[0] = in_fault;
        data_d[0]  = in_data;
        for (int k = 1; k < LATENCY; k++) begin
            valid_d[k] = valid_q[k-1];
            fault_d[k] = fault_q[k-1];
            data_d[k]  = data_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            fault_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_fault = fault_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_memory.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_memory
// Description : Byte-addressed little-endian data memory with
//               NUM_READ_PORTS registered read ports (fixed READ_LATENCY)
//               and one byte-count write port. Out-of-range accesses are
//               flagged, never aliased. Optionally zeroes the array after
//               reset, one word per cycle.
// Ports       : clk, rst                      - clock, sync active-high reset
//               rd_req/rd_addr/rd_ready       - per-port read request
//               rd_valid/rd_data/rd_fault     - per-port read response
//               wr_req/wr_addr/wr_bytes/wr_data/wr_ready - write request
//               wr_fault                      - rejected-write pulse
//               busy                          - clear sweep in progress
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [63:0] MEM_BYTE_SIZE  = 64'h1000,
    parameter int          NUM_READ_PORTS = 2,
    parameter int          READ_LATENCY   = 1,
    parameter int          CLEAR_ON_RESET = 1,
    localparam int DATA_BYTE_SIZE      = DATA_WIDTH / 8,
    localparam int DATA_INDEXING_WIDTH = $clog2(DATA_BYTE_SIZE)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_READ_PORTS-1:0]                rd_req,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ_PORTS-1:0]                rd_ready,
    output logic [NUM_READ_PORTS-1:0]                rd_valid,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ_PORTS-1:0]                rd_fault,
    input  logic                                     wr_req,
    input  logic [ADDR_WIDTH-1:0]                    wr_addr,
    input  logic [DATA_INDEXING_WIDTH:0]             wr_bytes,
    input  logic [DATA_WIDTH-1:0]                    wr_data,
    output logic                                     wr_ready,
    output logic                                     wr_fault,
    output logic                                     busy
);

    localparam int MEM_BYTES = int'(MEM_BYTE_SIZE);
    localparam int MEM_IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    typedef logic [MEM_IDX_W-1:0]         idx_t;
    typedef logic [DATA_INDEXING_WIDTH:0] wb_t;

    localparam idx_t LAST_WORD_PTR = idx_t'(MEM_BYTES - DATA_BYTE_SIZE);

    logic [7:0] mem_q [MEM_BYTES];

    mem_state_e state_q, state_d;
    idx_t       clear_ptr_q, clear_ptr_d;
    logic       wr_fault_q, wr_fault_d;
    logic       ready;

    wb_t                       wr_len;
    logic                      wr_accept;
    logic                      wr_in_range;
    logic                      wr_commit;
    logic [DATA_BYTE_SIZE-1:0] wr_byte_en;
    idx_t                      wr_idx [DATA_BYTE_SIZE];

    logic [NUM_READ_PORTS-1:0]                 rd_accept;
    logic [NUM_READ_PORTS-1:0]                 rd_fault_in;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data_in;

    assign ready    = (state_q == MEM_READY);
    assign rd_ready = {NUM_READ_PORTS{ready}};
    assign wr_ready = ready;
    assign busy     = (state_q == MEM_CLEAR);
    assign wr_fault = wr_fault_q;

    // ------------------------------------------------------------------
    // Clear sequencer: one word per cycle, leaves after the last word.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        if (state_q == MEM_CLEAR) begin
            clear_ptr_d = clear_ptr_q + idx_t'(DATA_BYTE_SIZE);
            if (clear_ptr_q == LAST_WORD_PTR) begin
                state_d = MEM_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? MEM_CLEAR : MEM_READY;
            clear_ptr_q <= '0;
            wr_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            wr_fault_q  <= wr_fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Write decode. Oversized byte counts saturate at a full word; a
    // zero count is accepted but touches nothing and never faults.
    // ------------------------------------------------------------------
    always_comb begin
        wr_len      = (wr_bytes > wb_t'(DATA_BYTE_SIZE)) ? wb_t'(DATA_BYTE_SIZE) : wr_bytes;
        wr_accept   = wr_req && ready;
        wr_in_range = in_range(RANGE_WIDTH'(wr_addr), RANGE_WIDTH'(wr_len),
                               RANGE_WIDTH'(MEM_BYTE_SIZE));
        wr_commit   = wr_accept && (wr_len != '0) && wr_in_range;
        wr_fault_d  = wr_accept && (wr_len != '0) && !wr_in_range;
        for (int i = 0; i < DATA_BYTE_SIZE; i++) begin
            wr_byte_en[i] = wr_commit && (wb_t'(i) < wr_len);
            wr_idx[i]     = idx_t'(wr_addr) + idx_t'(i);
        end
    end

    // ------------------------------------------------------------------
    // Read sampling happens combinationally from the array as it stands
    // before this edge's write lands, which gives read-first ordering.
    // ------------------------------------------------------------------
    always_comb begin
        rd_accept   = '0;
        rd_fault_in = '0;
        rd_data_in  = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_accept[p] = rd_req[p] && ready;
            if (rd_accept[p]) begin
                if (in_range(RANGE_WIDTH'(rd_addr[p]), RANGE_WIDTH'(DATA_BYTE_SIZE),
                             RANGE_WIDTH'(MEM_BYTE_SIZE))) begin
                    for (int i = 0; i < DATA_BYTE_SIZE; i++) begin
                        rd_data_in[p][i*8 +: 8] = mem_q[idx_t'(rd_addr[p]) + idx_t'(i)];
                    end
                end else begin
                    rd_fault_in[p] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array storage: clear sweep has the array to itself while busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == MEM_CLEAR) begin
                for (int i = 0; i < DATA_BYTE_SIZE; i++) begin
                    mem_q[clear_ptr_q + idx_t'(i)] <= 8'h00;
                end
            end else begin
                for (int i = 0; i < DATA_BYTE_SIZE; i++) begin
                    if (wr_byte_en[i]) begin
                        mem_q[wr_idx[i]] <= wr_data[i*8 +: 8];
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read_port
            mem_read_pipe #(
                .DATA_WIDTH (DATA_WIDTH),
                .LATENCY    (READ_LATENCY)
            ) u_read_pipe (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (rd_accept[p]),
                .in_data   (rd_data_in[p]),
                .in_fault  (rd_fault_in[p]),
                .out_valid (rd_valid[p]),
                .out_data  (rd_data[p]),
                .out_fault (rd_fault[p])
            );
        end
    endgenerate

endmodule
`default_nettype wire
